// File: rtl/nes_loader_pkg.sv
// Shared constants and types for the flash-to-loader NES image streamer.
// The FSM state encoding is kept as plain constants for legacy tools.
package nes_loader_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    typedef logic [2:0]  state_t;
    typedef logic [21:0] len_t;

endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: generates SCK and moves one byte each way per load.
// A load on the closing edge of a byte chains the next byte with no gap.
module spi_byte_engine
    import nes_loader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       kill,
    input  logic [7:0] tx_byte,
    input  logic       spi_miso,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       rx_done,
    output logic [7:0] rx_next,
    output logic       byte_done
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic       active;
    logic [3:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic       tick;
    logic       last_bit;

    assign tick      = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == 3'd7);
    assign rx_next   = {rx_sh[6:0], spi_miso};
    assign rx_done   = active & tick & ~spi_clk & last_bit;
    assign byte_done = active & tick & spi_clk & last_bit;

    always_ff @(posedge clk) begin
        if (!reset_n || kill) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else if (load) begin
            active   <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= tx_byte;
            spi_mosi <= tx_byte[7];
            spi_clk  <= 1'b0;
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                if (!spi_clk) begin
                    // MISO is sampled on the same edge that raises SCK
                    spi_clk <= 1'b1;
                    rx_sh   <= rx_next;
                end else begin
                    spi_clk <= 1'b0;
                    if (last_bit) begin
                        active   <= 1'b0;
                        spi_mosi <= 1'b0;
                    end else begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        tx_sh    <= {tx_sh[6:0], 1'b0};
                        spi_mosi <= tx_sh[6];
                    end
                end
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/rom_flash_streamer.sv
// Streams an iNES image out of SPI flash (READ 03h) into the game loader.
// Sequences the byte engine through command, address and data phases.
module rom_flash_streamer
    import nes_loader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] base_addr,
    input  logic [21:0] length,
    input  logic        spi_miso,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic        dl_on,
    output logic        busy,
    output logic        done
);

    state_t      state;
    logic [23:0] addr_q;
    len_t        cnt;
    logic [1:0]  addr_idx;

    logic       eng_load;
    logic       eng_kill;
    logic [7:0] eng_tx;
    logic       rx_done;
    logic [7:0] rx_next;
    logic       byte_done;
    logic       last_byte;

    assign last_byte = (cnt == '0);

    always_comb begin
        eng_load = 1'b0;
        eng_kill = 1'b0;
        eng_tx   = 8'h00;
        case (state)
            ST_IDLE: begin
                eng_load = start && (length != '0);
                eng_tx   = SPI_CMD_READ;
            end
            ST_CMD: begin
                eng_kill = abort;
                eng_load = !abort && byte_done;
                eng_tx   = addr_q[23:16];
            end
            ST_ADDR: begin
                eng_kill = abort;
                eng_load = !abort && byte_done;
                eng_tx   = (addr_idx == 2'd2) ? 8'h00 : addr_q[23:16];
            end
            ST_DATA: begin
                eng_kill = abort || (byte_done && last_byte);
                eng_load = !abort && byte_done && !last_byte;
            end
            default: eng_kill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            cnt      <= '0;
            addr_idx <= '0;
            spi_cs_n <= 1'b1;
            dl_data  <= '0;
            dl_wr    <= 1'b0;
            dl_on    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            dl_wr <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        cnt      <= length;
                        addr_idx <= '0;
                        if (length == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_CMD;
                            spi_cs_n <= 1'b0;
                            dl_on    <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_CMD, ST_ADDR: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        spi_cs_n <= 1'b1;
                        dl_on    <= 1'b0;
                        busy     <= 1'b0;
                    end else if (byte_done) begin
                        addr_q <= {addr_q[15:0], 8'h00};
                        if (state == ST_CMD) begin
                            state <= ST_ADDR;
                        end else if (addr_idx == 2'd2) begin
                            state <= ST_DATA;
                        end else begin
                            addr_idx <= addr_idx + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        spi_cs_n <= 1'b1;
                        dl_on    <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        if (rx_done) begin
                            dl_data <= rx_next;
                            dl_wr   <= 1'b1;
                            cnt     <= cnt - 22'd1;
                        end
                        // count already reflects this byte's dl_wr
                        if (byte_done && last_byte) begin
                            state    <= ST_FINISH;
                            spi_cs_n <= 1'b1;
                            dl_on    <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (eng_load),
        .kill      (eng_kill),
        .tx_byte   (eng_tx),
        .spi_miso  (spi_miso),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .rx_done   (rx_done),
        .rx_next   (rx_next),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_rom_flash_streamer.sv
// Directed bench for rom_flash_streamer with a small SPI flash model.
// A second instance at CLK_DIV=1 checks the fastest byte cadence.
module tb_rom_flash_streamer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] base_addr = '0;
    logic [21:0] length = '0;
    logic        spi_miso = 1'b0;
    logic        spi_clk, spi_mosi, spi_cs_n;
    logic [7:0]  dl_data;
    logic        dl_wr, dl_on, busy, done;

    logic        start1 = 1'b0;
    logic        spi_clk1, spi_mosi1, spi_cs_n1;
    logic [7:0]  dl_data1;
    logic        dl_wr1, dl_on1, busy1, done1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rom_flash_streamer #(.CLK_DIV(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .spi_miso  (spi_miso),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .dl_data   (dl_data),
        .dl_wr     (dl_wr),
        .dl_on     (dl_on),
        .busy      (busy),
        .done      (done)
    );

    rom_flash_streamer #(.CLK_DIV(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start1),
        .abort     (1'b0),
        .base_addr (24'h000000),
        .length    (22'd3),
        .spi_miso  (1'b1),
        .spi_clk   (spi_clk1),
        .spi_mosi  (spi_mosi1),
        .spi_cs_n  (spi_cs_n1),
        .dl_data   (dl_data1),
        .dl_wr     (dl_wr1),
        .dl_on     (dl_on1),
        .busy      (busy1),
        .done      (done1)
    );

    // flash model: header bits captured, data bytes served from fdata
    logic [7:0]  fdata [0:15];
    int          bitcnt = 0;
    logic [31:0] mosi_hdr = '0;
    int          mosi_nz = 0;

    always @(posedge spi_clk) begin
        if (bitcnt < 32) mosi_hdr = {mosi_hdr[30:0], spi_mosi};
        else if (spi_mosi) mosi_nz++;
        bitcnt++;
    end

    always @(negedge spi_clk or negedge spi_cs_n) begin
        int k;
        logic [7:0] b;
        k = bitcnt - 32;
        if (bitcnt >= 32) begin
            b = fdata[(k >> 3) & 15];
            spi_miso = b[7 - (k & 7)];
        end else begin
            spi_miso = 1'b0;
        end
    end

    int cyc = 0;
    int cs_low = 0, on_cnt = 0, done_cnt = 0, nwr = 0;
    logic [7:0] wr_byte [0:15];
    int wr_cyc [0:15];
    int cs1_low = 0, done1_cnt = 0, nwr1 = 0;
    logic [7:0] wr1_byte [0:15];
    int wr1_cyc [0:15];

    always @(negedge clk) begin
        cyc++;
        if (!spi_cs_n) cs_low++;
        if (dl_on) on_cnt++;
        if (done) done_cnt++;
        if (dl_wr) begin
            wr_byte[nwr & 15] = dl_data;
            wr_cyc[nwr & 15] = cyc;
            nwr++;
        end
        if (!spi_cs_n1) cs1_low++;
        if (done1) done1_cnt++;
        if (dl_wr1) begin
            wr1_byte[nwr1 & 15] = dl_data1;
            wr1_cyc[nwr1 & 15] = cyc;
            nwr1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        cs_low = 0; on_cnt = 0; done_cnt = 0; nwr = 0;
        bitcnt = 0; mosi_hdr = '0; mosi_nz = 0;
    endtask

    task automatic kick(input logic [23:0] a, input logic [21:0] l);
        base_addr = a;
        length = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt != 0), 32'd1);
        tick();
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs_n"}, 32'(spi_cs_n), 32'd1);
        check({tag, "_sck"}, 32'(spi_clk), 32'd0);
        check({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
        check({tag, "_data"}, 32'(dl_data), 32'd0);
        check({tag, "_wr"}, 32'(dl_wr), 32'd0);
        check({tag, "_on"}, 32'(dl_on), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) fdata[i] = 8'(8'hA0 + i);
        fdata[0] = 8'h4E;
        fdata[1] = 8'h45;
        fdata[2] = 8'h53;

        reset_n = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // basic 3-byte read, with a stray start while busy
        clr();
        kick(24'h100000, 22'd3);
        check("t1_cs_low", 32'(spi_cs_n), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_dl_on", 32'(dl_on), 32'd1);
        repeat (40) tick();
        kick(24'hABCDEF, 22'd7);
        wait_done("t1_done_seen", 1000);
        check("t1_hdr", mosi_hdr, 32'h03100000);
        check("t1_mosi_data0", 32'(mosi_nz), 32'd0);
        check("t1_bits", 32'(bitcnt), 32'd56);
        check("t1_nwr", 32'(nwr), 32'd3);
        check("t1_b0", 32'(wr_byte[0]), 32'h4E);
        check("t1_b1", 32'(wr_byte[1]), 32'h45);
        check("t1_b2", 32'(wr_byte[2]), 32'h53);
        check("t1_gap0", 32'(wr_cyc[1] - wr_cyc[0]), 32'd32);
        check("t1_gap1", 32'(wr_cyc[2] - wr_cyc[1]), 32'd32);
        check("t1_cs_cycles", 32'(cs_low), 32'd224);
        check("t1_on_cycles", 32'(on_cnt), 32'd224);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_hold", 32'(dl_data), 32'h53);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // zero-length request
        clr();
        kick(24'h000001, 22'd0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cs_n", 32'(spi_cs_n), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        tick();
        check("t2_done_off", 32'(done), 32'd0);
        repeat (5) tick();
        check("t2_cs_cycles", 32'(cs_low), 32'd0);
        check("t2_on_cycles", 32'(on_cnt), 32'd0);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // abort after the second byte of ten
        clr();
        kick(24'h000200, 22'd10);
        n = 0;
        while (nwr < 2 && n < 2000) begin
            tick();
            n++;
        end
        check("t3_two_bytes", 32'(nwr), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_cs_n", 32'(spi_cs_n), 32'd1);
        check("t3_sck", 32'(spi_clk), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_on", 32'(dl_on), 32'd0);
        repeat (300) tick();
        check("t3_nwr", 32'(nwr), 32'd2);
        check("t3_done_cnt", 32'(done_cnt), 32'd0);
        check("t3_hold", 32'(dl_data), 32'h45);

        // reset in the address phase, then a clean restart
        clr();
        kick(24'h123456, 22'd2);
        n = 0;
        while (bitcnt < 12 && n < 2000) begin
            tick();
            n++;
        end
        check("t4_in_addr", 32'(bitcnt >= 12 && bitcnt < 32), 32'd1);
        reset_n = 1'b0;
        tick();
        check_reset_vals("t4_rst");
        reset_n = 1'b1;
        tick();
        check("t4_no_wr", 32'(nwr), 32'd0);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        clr();
        kick(24'h123456, 22'd2);
        wait_done("t4_done_seen", 1000);
        check("t4_hdr", mosi_hdr, 32'h03123456);
        check("t4_nwr", 32'(nwr), 32'd2);
        check("t4_b0", 32'(wr_byte[0]), 32'h4E);
        check("t4_b1", 32'(wr_byte[1]), 32'h45);
        check("t4_cs_cycles", 32'(cs_low), 32'd192);
        check("t4_done_cnt", 32'(done_cnt), 32'd1);

        // fastest divider
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (done1_cnt == 0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        check("t5_done_cnt", 32'(done1_cnt), 32'd1);
        check("t5_nwr", 32'(nwr1), 32'd3);
        check("t5_gap0", 32'(wr1_cyc[1] - wr1_cyc[0]), 32'd16);
        check("t5_gap1", 32'(wr1_cyc[2] - wr1_cyc[1]), 32'd16);
        check("t5_b2", 32'(wr1_byte[2]), 32'hFF);
        check("t5_cs_cycles", 32'(cs1_low), 32'd112);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
